// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Drains the UART RX FIFO one byte at a time and parses framed commands of
//   the form SYNC, LEN, LEN payload bytes, XOR checksum (seeded with LEN).
//   Payload bytes are streamed downstream over valid/ready before the
//   checksum is known; a frame_err_p pulse tells the consumer to discard.
//   Optional feature macro: UART_RX_FRAME_TIMEOUT_EN enables the inter-byte
//   timeout (error code 3). Without it a stalled frame waits indefinitely.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 640
) (
    input  logic        clk210_p,
    input  logic        reset_p,
    input  logic        baud_16_x_p,
    input  logic [7:0]  fifo_rx_dout_p,
    input  logic        fifo_rx_empty_p,
    output logic        fifo_rx_rd_en_p,
    output logic [7:0]  out_data_p,
    output logic        out_valid_p,
    input  logic        out_ready_p,
    output logic        frame_done_p,
    output logic        frame_err_p,
    output logic [1:0]  err_code_p,
    output logic [7:0]  frame_len_p,
    output logic [15:0] frame_count_p,
    output logic        busy_p
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLD,
        ST_CKSUM
    } state_t;

    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    state_t      state_q, state_d;
    logic        rd_en_q, rd_en_d;          // read strobe presented to the FIFO
    logic        cap_q, cap_d;              // FIFO dout holds a fresh byte this cycle
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  rem_q, rem_d;              // payload bytes still to hand off
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  frame_len_q, frame_len_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        tmo_hit;

`ifdef UART_RX_FRAME_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Inter-byte timeout: counts baud ticks only while genuinely starved of input.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        if (state_q == ST_HUNT || cap_q) begin
            tmo_cnt_d = '0;
        end else if (baud_16_x_p && fifo_rx_empty_p && !rd_en_q && !out_valid_q) begin
            if (tmo_cnt_q == 16'(TIMEOUT_TICKS - 1)) begin
                tmo_hit   = 1'b1;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    // Tick input and timeout parameter are only meaningful with the timeout built in.
    logic unused_tmo;
    assign unused_tmo = ^{baud_16_x_p, 16'(TIMEOUT_TICKS)};
    assign tmo_hit    = 1'b0;
`endif

    // Fetch sequencing, frame parser and output generation.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d       = state_q;
        chk_d         = chk_q;
        rem_d         = rem_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_len_d   = frame_len_q;
        frame_count_d = frame_count_q;
        cap_d         = rd_en_q;

        // One read in flight at a time; a held payload byte blocks fetching
        // unless it is being accepted this cycle.
        rd_en_d = !fifo_rx_empty_p && !rd_en_q && !cap_q &&
                  (!out_valid_q || out_ready_p);

        unique case (state_q)
            ST_HUNT: begin
                if (cap_q && fifo_rx_dout_p == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (cap_q) begin
                    frame_len_d = fifo_rx_dout_p;
                    chk_d       = fifo_rx_dout_p;
                    rem_d       = fifo_rx_dout_p;
                    if (fifo_rx_dout_p == 8'd0 || fifo_rx_dout_p > 8'(MAX_LEN)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_HUNT;
                    end else begin
                        state_d = ST_PAYLD;
                    end
                end
            end
            ST_PAYLD: begin
                if (out_valid_q && out_ready_p) begin
                    out_valid_d = 1'b0;
                    rem_d       = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_CKSUM;
                    end
                end
                if (cap_q) begin
                    chk_d       = chk_q ^ fifo_rx_dout_p;
                    out_data_d  = fifo_rx_dout_p;
                    out_valid_d = 1'b1;
                end
            end
            ST_CKSUM: begin
                if (cap_q) begin
                    if (fifo_rx_dout_p == chk_q) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                    state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        if (tmo_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
            out_valid_d = 1'b0;
            state_d     = ST_HUNT;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk210_p) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (reset_p) begin
            state_q       <= ST_HUNT;
            rd_en_q       <= 1'b0;
            cap_q         <= 1'b0;
            chk_q         <= '0;
            rem_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= '0;
            frame_len_q   <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rd_en_q       <= rd_en_d;
            cap_q         <= cap_d;
            chk_q         <= chk_d;
            rem_q         <= rem_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_len_q   <= frame_len_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign fifo_rx_rd_en_p = rd_en_q;
    assign out_data_p      = out_data_q;
    assign out_valid_p     = out_valid_q;
    assign frame_done_p    = frame_done_q;
    assign frame_err_p     = frame_err_q;
    assign err_code_p      = err_code_q;
    assign frame_len_p     = frame_len_q;
    assign frame_count_p   = frame_count_q;
    assign busy_p          = (state_q != ST_HUNT);

endmodule
